uart_cmd_parser: RTL and testbench

Frame-level controller sitting directly behind the UART byte receiver. Consumes the receiver's one-cycle byte strobes, delimits command frames (sync, command, length, payload, checksum), validates length and checksum, and enforces an inter-byte timeout. Validated frames are buffered and presented to the command-execution logic with a valid/ack handshake; malformed frames are dropped with an error pulse.

---
 rtl/uart_cmd_pkg.sv | 20 ++
 rtl/uart_cmd_buf.sv | 32 +++
 rtl/uart_cmd_parser.sv | 168 ++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared state encoding and error codes for the UART command parser
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_SYNC    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4,
        ST_HOLD    = 3'd5
    } state_e;

    localparam logic [1:0] ERR_OVERRUN = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN = 2'd1;
    localparam logic [1:0] ERR_BAD_CHK = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_cmd_buf.sv
// rtl/uart_cmd_buf.sv - payload register file, one sync write port and one combinational read port
module uart_cmd_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];

    // Next-state of the array: only the addressed entry changes on a write
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Payload storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - UART command frame parser with length, checksum and inter-byte timeout checks
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CLKS = 12000,
    localparam int        AW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          cmd_valid,
    output logic [7:0]    cmd_code,
    output logic [7:0]    cmd_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          cmd_ack,
    output logic          err_pulse,
    output logic [1:0]    err_code,
    output logic          busy
);

    localparam int            CW        = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    state_e        state_q, state_d;
    logic [7:0]    code_q, code_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          err_pulse_q, err_pulse_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          buf_we;

    // Frame delimiting, validation and timeout; computes every next-state value
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        len_d       = len_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        cnt_d       = '0;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        buf_we      = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = ST_CMD;
                end
            end
            ST_HOLD: begin
                // An ack frees the frame immediately, so a coincident byte is a SYNC-state byte
                if (cmd_ack) begin
                    state_d = (rx_valid && rx_data == SYNC_BYTE) ? ST_CMD : ST_SYNC;
                end else if (rx_valid) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
            end
            default: begin
                // A byte in the expiry cycle takes priority over the timeout
                if (rx_valid) begin
                    case (state_q)
                        ST_CMD: begin
                            code_d  = rx_data;
                            sum_d   = rx_data;
                            state_d = ST_LEN;
                        end
                        ST_LEN: begin
                            if (rx_data > MAX_LEN_B) begin
                                err_pulse_d = 1'b1;
                                err_code_d  = ERR_BAD_LEN;
                                state_d     = ST_SYNC;
                            end else begin
                                len_d   = rx_data;
                                sum_d   = sum_q + rx_data;
                                idx_d   = '0;
                                state_d = (rx_data == 8'd0) ? ST_CHECK : ST_PAYLOAD;
                            end
                        end
                        ST_PAYLOAD: begin
                            buf_we = 1'b1;
                            sum_d  = sum_q + rx_data;
                            idx_d  = idx_q + 8'd1;
                            if (8'(idx_q + 8'd1) == len_q) begin
                                state_d = ST_CHECK;
                            end
                        end
                        ST_CHECK: begin
                            if (8'(sum_q + rx_data) == 8'd0) begin
                                state_d = ST_HOLD;
                            end else begin
                                err_pulse_d = 1'b1;
                                err_code_d  = ERR_BAD_CHK;
                                state_d     = ST_SYNC;
                            end
                        end
                        default: state_d = ST_SYNC;
                    endcase
                end else if (cnt_q == CNT_LAST) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = ST_SYNC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase

        valid_d = (state_d == ST_HOLD);
        busy_d  = (state_d != ST_SYNC);
    end

    // Parser state, frame fields and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SYNC;
            code_q      <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
        end
    end

    uart_cmd_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx_q[AW-1:0]),
        .wdata (rx_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign cmd_valid = valid_q;
    assign cmd_code  = code_q;
    assign cmd_len   = len_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed and randomized frame checks for uart_cmd_parser
module tb_uart_cmd_parser;

    localparam int         MAX_LEN      = 16;
    localparam int         TIMEOUT_CLKS = 40;
    localparam int         AW           = $clog2(MAX_LEN);
    localparam logic [7:0] SYNC         = 8'hA5;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          cmd_valid;
    logic [7:0]    cmd_code;
    logic [7:0]    cmd_len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          cmd_ack;
    logic          err_pulse;
    logic [1:0]    err_code;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] tx_pl[$];
    logic [7:0] exp_pl[$];
    logic [7:0] exp_code;
    logic [7:0] exp_len;

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .MAX_LEN      (MAX_LEN),
        .SYNC_BYTE    (SYNC),
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_len   (cmd_len),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .cmd_ack   (cmd_ack),
        .err_pulse (err_pulse),
        .err_code  (err_code),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic gap(input int maxgap);
        idle(int'($urandom_range(0, maxgap)));
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    function automatic logic [7:0] calc_chk(input logic [7:0] cmd, input logic [7:0] len);
        int total;
        total = int'(cmd) + int'(len);
        foreach (tx_pl[i]) total += int'(tx_pl[i]);
        return 8'((256 - (total % 256)) % 256);
    endfunction

    task automatic check_held(input string tag);
        check({tag, "_valid"}, cmd_valid, 1);
        check({tag, "_code"}, cmd_code, exp_code);
        check({tag, "_len"}, cmd_len, exp_len);
        for (int i = 0; i < int'(exp_len); i++) begin
            rd_addr = AW'(i);
            tick();
            check({tag, "_rd_data"}, rd_data, exp_pl[i]);
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [7:0] len,
                             input logic [7:0] chk, input int maxgap, output bit accepted);
        int total;
        accepted = 1'b0;
        send(SYNC);
        check({tag, "_busy_sync"}, busy, 1);
        gap(maxgap);
        send(cmd);
        check({tag, "_noerr_cmd"}, err_pulse, 0);
        gap(maxgap);
        send(len);
        if (int'(len) > MAX_LEN) begin
            check({tag, "_badlen_pulse"}, err_pulse, 1);
            check({tag, "_badlen_code"}, err_code, 1);
            tick();
            check({tag, "_badlen_once"}, err_pulse, 0);
            check({tag, "_badlen_busy"}, busy, 0);
        end else begin
            check({tag, "_noerr_len"}, err_pulse, 0);
            foreach (tx_pl[i]) begin
                gap(maxgap);
                send(tx_pl[i]);
            end
            gap(maxgap);
            send(chk);
            total = int'(cmd) + int'(len) + int'(chk);
            foreach (tx_pl[i]) total += int'(tx_pl[i]);
            if (total % 256 == 0) begin
                accepted = 1'b1;
                exp_code = cmd;
                exp_len  = len;
                exp_pl   = tx_pl;
                check({tag, "_ok_noerr"}, err_pulse, 0);
                check_held(tag);
            end else begin
                check({tag, "_badchk_pulse"}, err_pulse, 1);
                check({tag, "_badchk_code"}, err_code, 2);
                check({tag, "_badchk_valid"}, cmd_valid, 0);
                tick();
                check({tag, "_badchk_busy"}, busy, 0);
            end
        end
    endtask

    task automatic ack(input string tag);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check({tag, "_ack_valid"}, cmd_valid, 0);
        check({tag, "_ack_busy"}, busy, 0);
    endtask

    initial begin
        bit         ok;
        logic [7:0] b;
        logic [7:0] cmd;
        logic [7:0] len;
        logic [7:0] chk;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        cmd_ack  = 1'b0;
        rd_addr  = '0;
        idle(3);
        check("rst_valid", cmd_valid, 0);
        check("rst_code", cmd_code, 0);
        check("rst_len", cmd_len, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_code", err_code, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        tx_pl = {8'h11, 8'h22};
        run_frame("basic", 8'h01, 8'd2, 8'hCA, 0, ok);
        ack("basic");
        run_frame("basic_cc", 8'h01, 8'd2, 8'hCC, 0, ok);

        tx_pl = {};
        run_frame("len0", 8'h07, 8'd0, 8'hF9, 0, ok);
        ack("len0");
        run_frame("len0_bad", 8'h07, 8'd0, 8'hF8, 0, ok);

        run_frame("badlen", 8'h03, 8'h11, 8'h00, 0, ok);
        tx_pl = {8'h55};
        run_frame("after_badlen", 8'h03, 8'd1, 8'hA7, 0, ok);
        ack("after_badlen");

        send(SYNC);
        send(8'h01);
        idle(TIMEOUT_CLKS - 1);
        check("tmo_before_pulse", err_pulse, 0);
        check("tmo_before_busy", busy, 1);
        tick();
        check("tmo_pulse", err_pulse, 1);
        check("tmo_code", err_code, 3);
        tick();
        check("tmo_once", err_pulse, 0);
        check("tmo_busy", busy, 0);

        send(SYNC);
        send(8'h01);
        idle(TIMEOUT_CLKS - 1);
        send(8'h00);
        check("tmo_edge_noerr", err_pulse, 0);
        check("tmo_edge_busy", busy, 1);
        send(8'hFF);
        exp_code = 8'h01;
        exp_len  = 8'd0;
        exp_pl   = {};
        check_held("tmo_edge");
        ack("tmo_edge");

        tx_pl = {8'hDE, 8'hAD, 8'hBE};
        run_frame("ovr", 8'h5A, 8'd3, calc_chk(8'h5A, 8'd3), 0, ok);
        send(8'h42);
        check("ovr_pulse", err_pulse, 1);
        check("ovr_code", err_code, 0);
        check_held("ovr_held");
        check("ovr_once", err_pulse, 0);

        rx_data  = SYNC;
        rx_valid = 1'b1;
        cmd_ack  = 1'b1;
        tick();
        rx_valid = 1'b0;
        cmd_ack  = 1'b0;
        check("ackrx_valid", cmd_valid, 0);
        check("ackrx_busy", busy, 1);
        check("ackrx_noerr", err_pulse, 0);
        send(8'h09);
        send(8'h00);
        send(8'hF7);
        exp_code = 8'h09;
        exp_len  = 8'd0;
        exp_pl   = {};
        check_held("ackrx");
        ack("ackrx");

        send(SYNC);
        send(8'h01);
        send(8'h04);
        send(8'h11);
        send(8'h22);
        rst = 1'b1;
        tick();
        check("midrst_valid", cmd_valid, 0);
        check("midrst_code", cmd_code, 0);
        check("midrst_len", cmd_len, 0);
        check("midrst_pulse", err_pulse, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("midrst_after_pulse", err_pulse, 0);
        send(8'h00);
        send(8'hFF);
        check("junk_busy", busy, 0);
        check("junk_noerr", err_pulse, 0);
        tx_pl = {8'h11, 8'h22};
        run_frame("post_rst", 8'h01, 8'd2, 8'hCA, 0, ok);
        ack("post_rst");

        for (int n = 0; n < 40; n++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                send(b);
                check("rnd_junk_busy", busy, 0);
                check("rnd_junk_noerr", err_pulse, 0);
            end
            cmd = 8'($urandom);
            len = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, MAX_LEN));
            tx_pl = {};
            if (int'(len) <= MAX_LEN) begin
                for (int j = 0; j < int'(len); j++) tx_pl.push_back(8'($urandom));
            end
            chk = calc_chk(cmd, len);
            if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            run_frame("rnd", cmd, len, chk, 3, ok);
            if (ok) begin
                if ($urandom_range(0, 1) == 1) begin
                    send(8'($urandom));
                    check("rnd_ovr_pulse", err_pulse, 1);
                    check("rnd_ovr_code", err_code, 0);
                    check_held("rnd_ovr");
                end
                ack("rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
